// File: rtl/pipe_defs.sv
// Shared stall-vector constants, FSM state encoding and the zero word for the pipeline sequencer.
package pipe_defs;

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MC_BUSY = 2'd1,
    FLUSH   = 2'd2
  } state_e;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;

endpackage

// File: rtl/mc_counter.sv
// Loadable down-counter for EX multi-cycle ops; o_tc flags the last busy cycle (count == 1).
module mc_counter #(
  parameter int unsigned MC_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_load,
  input  logic [MC_W-1:0] i_value,
  input  logic            i_dec,
  output logic            o_tc
);

  logic [MC_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - MC_W'(1);
    end
  end

  assign o_tc = (r_count == MC_W'(1));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: stall mux, multi-cycle hold and one-cycle flush/redirect.
// Optional stall-cycle counter on o_stall_cnt enabled by `define PIPE_CTRL_PERF_EN.
module pipe_ctrl
  import pipe_defs::*;
#(
  parameter int unsigned MC_W = 6,
  parameter int unsigned PC_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_if_stallreq,
  input  logic            i_id_stallreq,
  input  logic            i_ex_stallreq,
  input  logic            i_ex_mc_start,
  input  logic [MC_W-1:0] i_ex_mc_cycles,
  input  logic            i_flush_req,
  input  logic [PC_W-1:0] i_flush_pc,
  output logic [5:0]      o_stall,
  output logic            o_flush,
  output logic [PC_W-1:0] o_new_pc,
  output logic            o_mc_busy,
  output logic            o_mc_done,
  output logic [31:0]     o_stall_cnt
);

  state_e          r_state;
  logic            r_flush;
  logic [PC_W-1:0] r_new_pc;
  logic            r_mc_busy;
  logic            r_mc_done;

  logic            w_mc_long;
  logic            w_load;
  logic [MC_W-1:0] w_value;
  logic            w_tc;
  logic [5:0]      w_stall;

  assign w_mc_long = (i_ex_mc_cycles >= MC_W'(2));
  // Load the remaining length on a long-op start; load zero when a flush aborts the op.
  assign w_load  = ((r_state == IDLE) && !i_flush_req && i_ex_mc_start && w_mc_long) ||
                   ((r_state == MC_BUSY) && i_flush_req);
  assign w_value = (r_state == IDLE) ? (i_ex_mc_cycles - MC_W'(1)) : '0;

  mc_counter #(
    .MC_W (MC_W)
  ) u_mc_counter (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_value (w_value),
    .i_dec   (r_state == MC_BUSY),
    .o_tc    (w_tc)
  );

  always_comb begin
    w_stall = STALL_NONE;
    if (rst || (r_state == FLUSH)) begin
      w_stall = STALL_NONE;
    end else if ((r_state == MC_BUSY) || i_ex_stallreq) begin
      w_stall = STALL_EX;
    end else if (i_id_stallreq) begin
      w_stall = STALL_ID;
    end else if (i_if_stallreq) begin
      w_stall = STALL_IF;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_flush   <= 1'b0;
      r_new_pc  <= PC_W'(ZeroWord);
      r_mc_busy <= 1'b0;
      r_mc_done <= 1'b0;
    end else begin
      r_flush   <= 1'b0;
      r_mc_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_flush_req) begin
            r_state  <= FLUSH;
            r_flush  <= 1'b1;
            r_new_pc <= i_flush_pc;
          end else if (i_ex_mc_start) begin
            if (w_mc_long) begin
              r_state   <= MC_BUSY;
              r_mc_busy <= 1'b1;
            end else begin
              r_mc_done <= 1'b1;
            end
          end
        end
        MC_BUSY: begin
          if (i_flush_req) begin
            r_state   <= FLUSH;
            r_flush   <= 1'b1;
            r_new_pc  <= i_flush_pc;
            r_mc_busy <= 1'b0;
          end else if (w_tc) begin
            r_state   <= IDLE;
            r_mc_busy <= 1'b0;
            r_mc_done <= 1'b1;
          end
        end
        FLUSH: begin
          if (i_flush_req) begin
            r_flush  <= 1'b1;
            r_new_pc <= i_flush_pc;
          end else begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= ZeroWord;
    end else if (w_stall[0] && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign o_stall_cnt = r_stall_cnt;
`else
  assign o_stall_cnt = ZeroWord;
`endif

  assign o_stall   = w_stall;
  assign o_flush   = r_flush;
  assign o_new_pc  = r_new_pc;
  assign o_mc_busy = r_mc_busy;
  assign o_mc_done = r_mc_done;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl; inputs driven 1 time unit after posedge, outputs
// sampled at negedge.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_if_stallreq;
  logic        i_id_stallreq;
  logic        i_ex_stallreq;
  logic        i_ex_mc_start;
  logic [5:0]  i_ex_mc_cycles;
  logic        i_flush_req;
  logic [31:0] i_flush_pc;
  logic [5:0]  o_stall;
  logic        o_flush;
  logic [31:0] o_new_pc;
  logic        o_mc_busy;
  logic        o_mc_done;
  logic [31:0] o_stall_cnt;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(
    .MC_W (6),
    .PC_W (32)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_if_stallreq  (i_if_stallreq),
    .i_id_stallreq  (i_id_stallreq),
    .i_ex_stallreq  (i_ex_stallreq),
    .i_ex_mc_start  (i_ex_mc_start),
    .i_ex_mc_cycles (i_ex_mc_cycles),
    .i_flush_req    (i_flush_req),
    .i_flush_pc     (i_flush_pc),
    .o_stall        (o_stall),
    .o_flush        (o_flush),
    .o_new_pc       (o_new_pc),
    .o_mc_busy      (o_mc_busy),
    .o_mc_done      (o_mc_done),
    .o_stall_cnt    (o_stall_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic check_ctl(input string tag, input logic [5:0] stall, input logic flush,
                           input logic busy, input logic done);
    check({tag, ".stall"}, {26'd0, o_stall}, {26'd0, stall});
    check({tag, ".flush"}, {31'd0, o_flush}, {31'd0, flush});
    check({tag, ".busy"},  {31'd0, o_mc_busy}, {31'd0, busy});
    check({tag, ".done"},  {31'd0, o_mc_done}, {31'd0, done});
  endtask

  logic [31:0] exp_perf;

  initial begin
`ifdef PIPE_CTRL_PERF_EN
    exp_perf = 32'd5;
`else
    exp_perf = 32'd0;
`endif
    rst            = 1'b1;
    i_if_stallreq  = 1'b1;
    i_id_stallreq  = 1'b1;
    i_ex_stallreq  = 1'b1;
    i_ex_mc_start  = 1'b1;
    i_ex_mc_cycles = 6'd5;
    i_flush_req    = 1'b1;
    i_flush_pc     = 32'hDEAD_BEEF;

    // Reset held with every request active.
    for (int i = 0; i < 2; i++) begin
      sample();
      check_ctl("rst", 6'b000000, 1'b0, 1'b0, 1'b0);
      check("rst.pc", o_new_pc, 32'h0);
      check("rst.cnt", o_stall_cnt, 32'h0);
    end
    tick();
    rst = 1'b0; i_if_stallreq = 1'b0; i_id_stallreq = 1'b0; i_ex_stallreq = 1'b0;
    i_ex_mc_start = 1'b0; i_flush_req = 1'b0;
    sample();
    check_ctl("idle", 6'b000000, 1'b0, 1'b0, 1'b0);

    // Five cycles of load-use stall feed the perf counter.
    tick();
    i_id_stallreq = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sample();
      check("id5.stall", {26'd0, o_stall}, 32'h07);
      tick();
    end
    i_id_stallreq = 1'b0;
    sample();
    check("perf.cnt", o_stall_cnt, exp_perf);

    // id + if together, then if alone, then ex.
    tick();
    i_id_stallreq = 1'b1; i_if_stallreq = 1'b1;
    sample();
    check("idif.stall", {26'd0, o_stall}, 32'h07);
    tick();
    i_id_stallreq = 1'b0;
    sample();
    check("if.stall", {26'd0, o_stall}, 32'h03);
    tick();
    i_if_stallreq = 1'b0; i_ex_stallreq = 1'b1; i_id_stallreq = 1'b1;
    sample();
    check("ex.stall", {26'd0, o_stall}, 32'h0F);
    tick();
    i_ex_stallreq = 1'b0; i_id_stallreq = 1'b0;

    // Multi-cycle op of 4: busy T+1..T+3, done at T+4.
    i_ex_mc_start = 1'b1; i_ex_mc_cycles = 6'd4;
    sample();
    check_ctl("mc4.T", 6'b000000, 1'b0, 1'b0, 1'b0);
    tick();
    i_ex_mc_start = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      sample();
      check_ctl("mc4.busy", 6'b001111, 1'b0, 1'b1, 1'b0);
      tick();
    end
    sample();
    check_ctl("mc4.done", 6'b000000, 1'b0, 1'b0, 1'b1);
    tick();
    sample();
    check_ctl("mc4.after", 6'b000000, 1'b0, 1'b0, 1'b0);

    // Short ops (1 and 0 cycles): no stall, done pulse next cycle.
    for (int c = 1; c >= 0; c--) begin
      tick();
      i_ex_mc_start = 1'b1; i_ex_mc_cycles = 6'(c);
      sample();
      check_ctl("short.T", 6'b000000, 1'b0, 1'b0, 1'b0);
      tick();
      i_ex_mc_start = 1'b0;
      sample();
      check_ctl("short.done", 6'b000000, 1'b0, 1'b0, 1'b1);
      tick();
      sample();
      check_ctl("short.after", 6'b000000, 1'b0, 1'b0, 1'b0);
    end

    // Flush aborts an 8-cycle op at its 3rd busy cycle.
    tick();
    i_ex_mc_start = 1'b1; i_ex_mc_cycles = 6'd8;
    tick();
    i_ex_mc_start = 1'b0;
    tick();
    tick();
    i_flush_req = 1'b1; i_flush_pc = 32'h0000_0100;
    sample();
    check_ctl("abort.busy3", 6'b001111, 1'b0, 1'b1, 1'b0);
    tick();
    i_flush_req = 1'b0; i_ex_stallreq = 1'b1;
    sample();
    check_ctl("abort.flush", 6'b000000, 1'b1, 1'b0, 1'b0);
    check("abort.pc", o_new_pc, 32'h0000_0100);
    tick();
    i_ex_stallreq = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sample();
      check_ctl("abort.idle", 6'b000000, 1'b0, 1'b0, 1'b0);
      tick();
    end

    // Back-to-back flush: last request wins, flush extends one cycle.
    i_flush_req = 1'b1; i_flush_pc = 32'h0000_0200;
    tick();
    i_flush_pc = 32'h0000_0300;
    sample();
    check("dbl.flush1", {31'd0, o_flush}, 32'd1);
    check("dbl.pc1", o_new_pc, 32'h0000_0200);
    tick();
    i_flush_req = 1'b0;
    sample();
    check("dbl.flush2", {31'd0, o_flush}, 32'd1);
    check("dbl.pc2", o_new_pc, 32'h0000_0300);
    tick();
    sample();
    check_ctl("dbl.end", 6'b000000, 1'b0, 1'b0, 1'b0);

    // Flush beats a simultaneous long mc start.
    tick();
    i_flush_req = 1'b1; i_flush_pc = 32'h0000_0400; i_ex_mc_start = 1'b1; i_ex_mc_cycles = 6'd4;
    tick();
    i_flush_req = 1'b0; i_ex_mc_start = 1'b0;
    sample();
    check_ctl("fvm.flush", 6'b000000, 1'b1, 1'b0, 1'b0);
    check("fvm.pc", o_new_pc, 32'h0000_0400);
    tick();
    sample();
    check_ctl("fvm.idle", 6'b000000, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
